// File: rtl/isa_vram_port.sv
// ISA-to-VRAM bridge: decodes a framebuffer window, posts CPU writes through a small FIFO
// drained in sequencer slots, and stalls CPU reads on bus_rdy until VRAM data is fetched.
module isa_vram_port #(
    parameter logic [19:0] FB_ADDR      = 20'hB8000,
    parameter int          FB_BITS      = 15,
    parameter int          RAM_AW       = 19,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          USE_BUS_WAIT = 1,
    parameter int          SYNC_STAGES  = 2,
    parameter int          RD_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic [19:0]               bus_a,
    input  logic [7:0]                bus_d,
    input  logic                      bus_memr_l,
    input  logic                      bus_memw_l,
    input  logic                      bus_aen,
    output logic [7:0]                bus_out,
    output logic                      bus_dir,
    output logic                      bus_rdy,
    input  logic [RAM_AW-FB_BITS-1:0] page_base,
    input  logic                      isa_slot,
    output logic [RAM_AW-1:0]         mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [7:0]                mem_rdata,
    output logic                      fifo_empty,
    output logic [1:0]                err_flags
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_SLOT, RD_CAP, RD_HOLD} rd_state_t;

    rd_state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] memr_sync_reg, memw_sync_reg;
    logic                   memr_prev_reg, memw_prev_reg;
    logic                   memr_s, memw_s, cs, rd_start, wr_start;

    logic [RAM_AW-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [7:0]        fifo_data_mem [FIFO_DEPTH];
    logic [FAW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [FAW:0]      count_reg;
    logic              full, empty, pop, push, can_push, capture, drop;
    logic [RAM_AW-1:0] push_addr, cur_addr;
    logic [7:0]        push_data;

    logic              hold_reg, wr_done_reg, rd_done, tmo_hit, rdy_wait;
    logic [RAM_AW-1:0] hold_addr_reg, rd_addr_reg, addr_last_reg;
    logic [7:0]        hold_data_reg, wdata_last_reg;
    logic [TW-1:0]     tmo_cnt_reg;

    assign memr_s   = memr_sync_reg[SYNC_STAGES-1];
    assign memw_s   = memw_sync_reg[SYNC_STAGES-1];
    assign cs       = (bus_a[19:FB_BITS] == FB_ADDR[19:FB_BITS]) & ~bus_aen;
    assign cur_addr = {page_base, bus_a[FB_BITS-1:0]};
    assign rd_start = cs & memr_prev_reg & ~memr_s & (state_reg == IDLE);
    // A write is ignored while a read strobe is also asserted.
    assign wr_start = cs & memw_prev_reg & ~memw_s & memr_s;

    assign full       = (count_reg == (FAW+1)'(FIFO_DEPTH));
    assign empty      = (count_reg == '0);
    assign fifo_empty = empty;
    assign pop        = isa_slot & ~empty & (state_reg != RD_SLOT);
    assign can_push   = ~full | pop;
    assign tmo_hit    = (tmo_cnt_reg == TW'(RD_TIMEOUT - 1)) &
                        ((state_reg == RD_DRAIN) | (state_reg == RD_SLOT));

    assign mem_we    = pop;
    assign mem_re    = isa_slot & (state_reg == RD_SLOT) & ~tmo_hit;
    assign mem_addr  = mem_we ? fifo_addr_mem[rd_ptr_reg] : (mem_re ? rd_addr_reg : addr_last_reg);
    assign mem_wdata = mem_we ? fifo_data_mem[rd_ptr_reg] : wdata_last_reg;

    // Stall is computed from the raw strobes so IOCHRDY drops before the synchroniser sees them.
    assign rd_done  = (state_reg == RD_HOLD);
    assign rdy_wait = cs & ((~bus_memr_l & ~rd_done) | (~bus_memw_l & bus_memr_l & ~wr_done_reg));
    assign bus_rdy  = (USE_BUS_WAIT != 0) ? ~rdy_wait : 1'b1;
    assign bus_dir  = cs & ~bus_memr_l;

    always_comb begin
        push      = 1'b0;
        capture   = 1'b0;
        drop      = 1'b0;
        push_addr = hold_addr_reg;
        push_data = hold_data_reg;
        if (hold_reg) begin
            push = can_push;
        end else if (wr_start) begin
            push_addr = cur_addr;
            push_data = bus_d;
            if (can_push)
                push = 1'b1;
            else if (USE_BUS_WAIT != 0)
                capture = 1'b1;
            else
                drop = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (rd_start) state_next = RD_DRAIN;
            RD_DRAIN: if (tmo_hit) state_next = RD_HOLD;
                      else if (empty && !hold_reg) state_next = RD_SLOT;
            RD_SLOT:  if (tmo_hit) state_next = RD_HOLD;
                      else if (isa_slot) state_next = RD_CAP;
            RD_CAP:   state_next = RD_HOLD;
            RD_HOLD:  if (memr_s) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_reg] <= push_addr;
            fifo_data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            memr_sync_reg  <= '1;
            memw_sync_reg  <= '1;
            memr_prev_reg  <= 1'b1;
            memw_prev_reg  <= 1'b1;
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            hold_reg       <= 1'b0;
            hold_addr_reg  <= '0;
            hold_data_reg  <= '0;
            wr_done_reg    <= 1'b0;
            rd_addr_reg    <= '0;
            tmo_cnt_reg    <= '0;
            bus_out        <= '0;
            err_flags      <= '0;
            addr_last_reg  <= '0;
            wdata_last_reg <= '0;
        end else begin
            memr_sync_reg <= {memr_sync_reg[SYNC_STAGES-2:0], bus_memr_l};
            memw_sync_reg <= {memw_sync_reg[SYNC_STAGES-2:0], bus_memw_l};
            memr_prev_reg <= memr_s;
            memw_prev_reg <= memw_s;
            state_reg     <= state_next;

            if (push) wr_ptr_reg <= wr_ptr_reg + FAW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + FAW'(1);
            if (push && !pop)      count_reg <= count_reg + (FAW+1)'(1);
            else if (pop && !push) count_reg <= count_reg - (FAW+1)'(1);

            if (capture) begin
                hold_reg      <= 1'b1;
                hold_addr_reg <= cur_addr;
                hold_data_reg <= bus_d;
            end else if (push) begin
                hold_reg <= 1'b0;
            end

            if (push || drop) wr_done_reg <= 1'b1;
            else if (memw_s)  wr_done_reg <= 1'b0;

            if (rd_start) begin
                rd_addr_reg <= cur_addr;
                tmo_cnt_reg <= '0;
            end else if ((state_reg == RD_DRAIN) || (state_reg == RD_SLOT)) begin
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
            end

            if (tmo_hit)                  bus_out <= 8'hFF;
            else if (state_reg == RD_CAP) bus_out <= mem_rdata;

            if (drop)    err_flags[0] <= 1'b1;
            if (tmo_hit) err_flags[1] <= 1'b1;

            if (mem_we) begin
                addr_last_reg  <= fifo_addr_mem[rd_ptr_reg];
                wdata_last_reg <= fifo_data_mem[rd_ptr_reg];
            end else if (mem_re) begin
                addr_last_reg  <= rd_addr_reg;
            end
        end
    end
endmodule
